// File: rtl/pet_combat_resolver.sv
// Two-pet combat resolver: simultaneous attack rounds until a knockout or a round limit.
// Optional macro COMBAT_CRIT_EN enables RNG-driven critical (double) damage.
module pet_combat_resolver #(
  parameter int MAX_ROUNDS = 8,
  parameter int ROUND_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] p1_pet,
  input  logic [8:0] p2_pet,
  input  logic [7:0] rand_byte,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [2:0] p1_hp,
  output logic [2:0] p2_hp,
  output logic [3:0] round_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ATTACK,
    S_CHECK,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] ROUND_LIMIT = 4'(MAX_ROUNDS);
  localparam logic [7:0] WAIT_LAST   = (ROUND_WAIT == 0) ? 8'd0 : 8'(ROUND_WAIT - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic [2:0] atk_reg [2];
  logic [2:0] def_reg [2];

  logic [2:0] hp_now   [2];
  logic [3:0] dmg_base [2];
  logic [3:0] dmg      [2];
  logic [3:0] hp_diff  [2];
  logic [2:0] hp_next  [2];

  logic unused_rand;
  assign unused_rand = ^rand_byte;

  assign hp_now[0] = p1_hp;
  assign hp_now[1] = p2_hp;

  // Index gi is the pet taking the hit; the attacker is the other pet.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign dmg_base[gi] = (atk_reg[1-gi] > def_reg[gi])
                          ? ({1'b0, atk_reg[1-gi]} - {1'b0, def_reg[gi]})
                          : 4'd1;
`ifdef COMBAT_CRIT_EN
      // Crit bits: rand[2:0] boosts the hit on P2, rand[5:3] the hit on P1.
      assign dmg[gi] = (rand_byte[3*(1-gi) +: 3] == 3'b111) ? (dmg_base[gi] << 1) : dmg_base[gi];
`else
      assign dmg[gi] = dmg_base[gi];
`endif
      assign hp_diff[gi] = {1'b0, hp_now[gi]} - dmg[gi];
      assign hp_next[gi] = ({1'b0, hp_now[gi]} > dmg[gi]) ? hp_diff[gi][2:0] : 3'd0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= 2'b00;
      p1_hp        <= 3'd0;
      p2_hp        <= 3'd0;
      round_count  <= 4'd0;
      atk_reg[0]   <= 3'd0;
      atk_reg[1]   <= 3'd0;
      def_reg[0]   <= 3'd0;
      def_reg[1]   <= 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg <= S_LOAD;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          atk_reg[0]  <= p1_pet[8:6];
          def_reg[0]  <= p1_pet[5:3];
          atk_reg[1]  <= p2_pet[8:6];
          def_reg[1]  <= p2_pet[5:3];
          p1_hp       <= p1_pet[2:0];
          p2_hp       <= p2_pet[2:0];
          winner      <= 2'b00;
          round_count <= 4'd0;
          if (p1_pet[2:0] == 3'd0 || p2_pet[2:0] == 3'd0)
            state_reg <= S_CHECK;
          else
            state_reg <= S_ATTACK;
        end
        S_ATTACK: begin
          p1_hp       <= hp_next[0];
          p2_hp       <= hp_next[1];
          round_count <= round_count + 4'd1;
          state_reg   <= S_CHECK;
        end
        S_CHECK: begin
          if (p1_hp == 3'd0 || p2_hp == 3'd0) begin
            if (p1_hp == 3'd0 && p2_hp == 3'd0) winner <= 2'b11;
            else if (p2_hp == 3'd0)             winner <= 2'b01;
            else                                winner <= 2'b10;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else if (round_count == ROUND_LIMIT) begin
            if (p1_hp > p2_hp)      winner <= 2'b01;
            else if (p2_hp > p1_hp) winner <= 2'b10;
            else                    winner <= 2'b11;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else if (ROUND_WAIT == 0) begin
            state_reg <= S_ATTACK;
          end else begin
            wait_cnt_reg <= 8'd0;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST)
            state_reg <= S_ATTACK;
          else
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pet_combat_resolver.sv
// Scoreboard bench for pet_combat_resolver: main instance uses defaults,
// a second instance uses MAX_ROUNDS=3 with no WAIT state.
module tb_pet_combat_resolver;

  typedef struct packed {
    logic [1:0] winner;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [3:0] rounds;
  } res_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start3;
  logic [8:0] p1_pet, p2_pet;
  logic [7:0] rand_byte;
  logic       busy, done, busy3, done3;
  logic [1:0] winner, winner3;
  logic [2:0] p1_hp, p2_hp, p1_hp3, p2_hp3;
  logic [3:0] round_count, round_count3;

  int   cyc = 0;
  int   done_cnt = 0;
  int   done3_cnt = 0;
  int   total = 0;
  int   bad = 0;
  res_t exp_q [$];
  int   lat_q [$];

  pet_combat_resolver dut (
    .clk(clk), .reset(reset), .start(start), .p1_pet(p1_pet), .p2_pet(p2_pet),
    .rand_byte(rand_byte), .busy(busy), .done(done), .winner(winner),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .round_count(round_count)
  );

  pet_combat_resolver #(.MAX_ROUNDS(3), .ROUND_WAIT(0)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .p1_pet(p1_pet), .p2_pet(p2_pet),
    .rand_byte(rand_byte), .busy(busy3), .done(done3), .winner(winner3),
    .p1_hp(p1_hp3), .p2_hp(p2_hp3), .round_count(round_count3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done3) done3_cnt <= done3_cnt + 1;
  end

  task automatic push_exp(input logic [1:0] w, input logic [2:0] a, input logic [2:0] b,
                          input logic [3:0] r, input int lat);
    res_t e;
    e = '{winner: w, p1: a, p2: b, rounds: r};
    exp_q.push_back(e);
    lat_q.push_back(lat);
  endtask

  task automatic pulse_start(input bit sel, output int n);
    @(posedge clk);
    #1;
    if (sel) start3 = 1'b1; else start = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  // Waits (bounded) for a done pulse and reports the outputs seen in that cycle.
  task automatic collect(input bit sel, input int n, output res_t r, output int lat);
    r   = '0;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sel ? done3 : done) begin
        r   = sel ? {winner3, p1_hp3, p2_hp3, round_count3} : {winner, p1_hp, p2_hp, round_count};
        lat = cyc - n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy, done, winner, p1_hp, p2_hp, round_count} !== 14'd0) begin
      bad++;
      $display("FAIL reset_in got=%h want=0", {busy, done, winner, p1_hp, p2_hp, round_count});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, winner, p1_hp, p2_hp, round_count} !== 14'd0) begin
      bad++;
      $display("FAIL reset_out got=%h want=0", {busy, done, winner, p1_hp, p2_hp, round_count});
    end
    total++;
    if ({busy3, done3, winner3, p1_hp3, p2_hp3, round_count3} !== 14'd0) begin
      bad++;
      $display("FAIL reset_dut3 got=%h want=0", {busy3, done3, winner3, p1_hp3, p2_hp3, round_count3});
    end
  endtask

  task automatic test_basic;
    logic [8:0] t_p1 [5] = '{9'h154, 9'h0CB, 9'h1C1, 9'h150, 9'h154};
    logic [8:0] t_p2 [5] = '{9'h0CB, 9'h154, 9'h1C7, 9'h0CB, 9'h0CB};
    logic [7:0] t_rnd [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [1:0] t_w  [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
    logic [2:0] t_a  [5] = '{3'd3, 3'd0, 3'd0, 3'd0, 3'd3};
    logic [2:0] t_b  [5] = '{3'd0, 3'd3, 3'd0, 3'd3, 3'd0};
    logic [3:0] t_r  [5] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    int         t_l  [5] = '{4, 4, 4, 3, 4};
    int n, lat, el;
    res_t r, e;
`ifdef COMBAT_CRIT_EN
    t_a[4] = 3'd2;
`endif
    for (int i = 0; i < 5; i++) begin
      p1_pet = t_p1[i];
      p2_pet = t_p2[i];
      rand_byte = t_rnd[i];
      push_exp(t_w[i], t_a[i], t_b[i], t_r[i], t_l[i]);
      pulse_start(1'b0, n);
      if (i == 0) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_in_load got=%b want=1", busy);
        end
      end
      collect(1'b0, n, r, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (r !== e) begin
        bad++;
        $display("FAIL basic%0d_result got=%h want=%h", i, r, e);
      end
      total++;
      if (lat != el) begin
        bad++;
        $display("FAIL basic%0d_latency got=%0d want=%0d", i, lat, el);
      end
    end
    @(negedge clk);
    total++;
    if ({busy, done, winner} !== {1'b0, 1'b0, t_w[4]}) begin
      bad++;
      $display("FAIL idle_hold got=%b want=%b", {busy, done, winner}, {1'b0, 1'b0, t_w[4]});
    end
    rand_byte = 8'h00;
  endtask

  task automatic test_long_fight;
    int n, lat, el;
    res_t r, e;
    p1_pet = 9'h07F;
    p2_pet = 9'h07F;
    push_exp(2'b11, 3'd0, 3'd0, 4'd7, 4 + 6 * (4 + 2));
    pulse_start(1'b0, n);
    collect(1'b0, n, r, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL long_result got=%h want=%h", r, e);
    end
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL long_latency got=%0d want=%0d", lat, el);
    end
  endtask

  task automatic test_round_limit;
    logic [8:0] t_p2 [2] = '{9'h07D, 9'h07F};
    logic [1:0] t_w  [2] = '{2'b01, 2'b11};
    logic [2:0] t_b  [2] = '{3'd2, 3'd4};
    int n, lat, el;
    res_t r, e;
    for (int i = 0; i < 2; i++) begin
      p1_pet = 9'h07F;
      p2_pet = t_p2[i];
      push_exp(t_w[i], 3'd4, t_b[i], 4'd3, 8);
      pulse_start(1'b1, n);
      collect(1'b1, n, r, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (r !== e) begin
        bad++;
        $display("FAIL limit%0d_result got=%h want=%h", i, r, e);
      end
      total++;
      if (lat != el) begin
        bad++;
        $display("FAIL limit%0d_latency got=%0d want=%0d", i, lat, el);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int n, lat, el, dc;
    res_t r, e;
    p1_pet = 9'h07F;
    p2_pet = 9'h07F;
    dc = done_cnt;
    push_exp(2'b11, 3'd0, 3'd0, 4'd7, 40);
    pulse_start(1'b0, n);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    p1_pet = 9'h154;
    collect(1'b0, n, r, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL busy_result got=%h want=%h", r, e);
    end
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL busy_latency got=%0d want=%0d", lat, el);
    end
    repeat (12) @(negedge clk);
    total++;
    if (done_cnt - dc != 1) begin
      bad++;
      $display("FAIL busy_done_pulses got=%0d want=1", done_cnt - dc);
    end
  endtask

  task automatic test_start_held;
    int n, lat, el, dc;
    res_t r, e;
    p1_pet = 9'h154;
    p2_pet = 9'h0CB;
    dc = done3_cnt;
    push_exp(2'b01, 3'd3, 3'd0, 4'd1, 4);
    push_exp(2'b01, 3'd3, 3'd0, 4'd1, 9);
    @(posedge clk);
    #1 start3 = 1'b1;
    n = cyc;
    for (int f = 0; f < 2; f++) begin
      collect(1'b1, n, r, lat);
      if (f == 0) begin
        @(posedge clk);
        @(posedge clk);
        #1 start3 = 1'b0;
      end
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (r !== e) begin
        bad++;
        $display("FAIL held%0d_result got=%h want=%h", f, r, e);
      end
      total++;
      if (lat != el) begin
        bad++;
        $display("FAIL held%0d_latency got=%0d want=%0d", f, lat, el);
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (done3_cnt - dc != 2) begin
      bad++;
      $display("FAIL held_done_pulses got=%0d want=2", done3_cnt - dc);
    end
  endtask

  task automatic test_reset_mid_fight;
    int n, lat, el, dc;
    res_t r, e;
    p1_pet = 9'h07F;
    p2_pet = 9'h07F;
    pulse_start(1'b0, n);
    repeat (9) @(posedge clk);
    dc = done_cnt;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, winner, p1_hp, p2_hp, round_count} !== 14'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {busy, done, winner, p1_hp, p2_hp, round_count});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (done_cnt != dc) begin
      bad++;
      $display("FAIL abort_done_pulses got=%0d want=0", done_cnt - dc);
    end
    p1_pet = 9'h154;
    p2_pet = 9'h0CB;
    push_exp(2'b01, 3'd3, 3'd0, 4'd1, 4);
    pulse_start(1'b0, n);
    collect(1'b0, n, r, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL rearm_result got=%h want=%h", r, e);
    end
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL rearm_latency got=%0d want=%0d", lat, el);
    end
  endtask

  task automatic test_crit;
    int n, lat, el;
    res_t r, e;
    p1_pet = 9'h154;
    p2_pet = 9'h0CB;
    rand_byte = 8'h07;
    push_exp(2'b01, 3'd3, 3'd0, 4'd1, 4);
    pulse_start(1'b0, n);
    collect(1'b0, n, r, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL crit_result got=%h want=%h", r, e);
    end
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL crit_latency got=%0d want=%0d", lat, el);
    end
    rand_byte = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    p1_pet = 9'h000;
    p2_pet = 9'h000;
    rand_byte = 8'h00;
    repeat (3) @(posedge clk);
    test_reset;
    test_basic;
    test_long_fight;
    test_round_limit;
    test_busy_ignore;
    test_start_held;
    test_reset_mid_fight;
    test_crit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
